perm_shift_ctrl: RTL and testbench

- Sequencer directly upstream of state_register; generates its write_en, shift_en, shift_type and last_cycle controls.
- Runs one ASCON permutation of num_rounds rounds. Each round is a substitution phase (masked, (d+1)*PAR bits/cycle) followed by a linear phase (PAR bits/cycle).
- Also supplies the per-round constant byte to the datapath.
- start/busy/done handshake to the top-level mode FSM.

---
 rtl/perm_shift_ctrl_pkg.sv | 36 +++
 rtl/perm_shift_ctrl_rc_lut.sv | 12 +
 rtl/perm_shift_ctrl.sv | 149 ++++++++++++++
 tb/tb_perm_shift_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/perm_shift_ctrl_pkg.sv
// Shared ASCON permutation-control parameters: state width, shift widths,
// derived per-phase cycle counts, controller state encoding and the
// round-constant helper used by the control path and the datapath.
package perm_shift_ctrl_pkg;

  localparam int WORD_SIZE_DEF          = 64;
  localparam int SHIFT_PAR_DEF          = 1;
  localparam int SHIFT_PAR_D_PLUS_1_DEF = 2;
  localparam int MAX_ROUNDS             = 12;

  // Cycles needed to stream one word at the given width; a width that
  // covers the whole word collapses to a single cycle.
  function automatic int phase_cycles(input int word_bits, input int step_bits);
    if (step_bits >= word_bits) begin
      return 1;
    end else begin
      return (word_bits + step_bits - 1) / step_bits;
    end
  endfunction

  localparam int N_SUB_CYC = phase_cycles(WORD_SIZE_DEF, SHIFT_PAR_D_PLUS_1_DEF);
  localparam int N_LIN_CYC = phase_cycles(WORD_SIZE_DEF, SHIFT_PAR_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_LIN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  // ASCON round constant for an absolute round index: 0xF0 - idx*0x0F.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return 8'hF0 - ({4'h0, idx} * 8'h0F);
  endfunction

endpackage

// File: rtl/perm_shift_ctrl_rc_lut.sv
// Round-constant lookup: absolute round index -> 8-bit ASCON constant.
// Purely combinational so the datapath constant-add stage can share it.
module perm_shift_ctrl_rc_lut
  import perm_shift_ctrl_pkg::*;
(
  input  logic [3:0] round_idx,
  output logic [7:0] rc
);

  assign rc = round_const(round_idx);

endmodule

// File: rtl/perm_shift_ctrl.sv
// Permutation sequencer feeding state_register: walks num_rounds ASCON
// rounds, each a substitution phase followed by a linear phase, and drives
// the shift controls, the per-round constant and the start/busy/done
// handshake. All controls except write_en are registered.
module perm_shift_ctrl
  import perm_shift_ctrl_pkg::*;
#(
  parameter int WORD_SIZE          = WORD_SIZE_DEF,
  parameter int SHIFT_PAR          = SHIFT_PAR_DEF,
  parameter int SHIFT_PAR_D_PLUS_1 = SHIFT_PAR_D_PLUS_1_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num_rounds,
  input  logic       load_req,
  output logic       write_en,
  output logic       shift_en,
  output logic       shift_type,
  output logic       last_cycle,
  output logic [3:0] round_idx,
  output logic [7:0] rc,
  output logic       busy,
  output logic       done
);

  localparam int N_SUB   = phase_cycles(WORD_SIZE, SHIFT_PAR_D_PLUS_1);
  localparam int N_LIN   = phase_cycles(WORD_SIZE, SHIFT_PAR);
  localparam int CNT_MAX = (N_SUB > N_LIN) ? N_SUB : N_LIN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SUB_LAST = CW'(N_SUB - 1);
  localparam logic [CW-1:0] LIN_LAST = CW'(N_LIN - 1);

  ctrl_state_t   state_r;
  logic [CW-1:0] cyc_cnt_r;
  logic [3:0]    rnd_cnt_r;     // rounds still to run after the current one
  logic [3:0]    round_idx_r;
  logic          shift_en_r;
  logic          shift_type_r;
  logic          last_cycle_r;
  logic          busy_r;
  logic          done_r;
  logic [CW-1:0] cyc_nxt_s;
  logic          start_ok_s;

  assign cyc_nxt_s  = cyc_cnt_r + CW'(1);
  assign start_ok_s = (num_rounds != 4'd0) && (num_rounds <= 4'(MAX_ROUNDS));

  // Parallel load is allowed only while idle and loses to a same-cycle start.
  assign write_en   = load_req & (state_r == ST_IDLE) & ~start;

  assign shift_en   = shift_en_r;
  assign shift_type = shift_type_r;
  assign last_cycle = last_cycle_r;
  assign round_idx  = round_idx_r;
  assign busy       = busy_r;
  assign done       = done_r;

  perm_shift_ctrl_rc_lut u_rc_lut (
    .round_idx (round_idx_r),
    .rc        (rc)
  );

  // Sequencer FSM; outputs are computed for the state being entered so they
  // line up with the cycle in which that state is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cyc_cnt_r    <= '0;
      rnd_cnt_r    <= 4'd0;
      round_idx_r  <= 4'd0;
      shift_en_r   <= 1'b0;
      shift_type_r <= 1'b0;
      last_cycle_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && start_ok_s) begin
            state_r      <= ST_SUB;
            cyc_cnt_r    <= '0;
            rnd_cnt_r    <= num_rounds - 4'd1;
            round_idx_r  <= 4'(MAX_ROUNDS) - num_rounds;
            shift_en_r   <= 1'b1;
            shift_type_r <= 1'b0;
            last_cycle_r <= (SUB_LAST == '0);
            busy_r       <= 1'b1;
          end else if (start) begin
            // Out-of-range round count completes without any shifting.
            state_r      <= ST_DONE;
            done_r       <= 1'b1;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_SUB: begin
          if (cyc_cnt_r == SUB_LAST) begin
            state_r      <= ST_LIN;
            cyc_cnt_r    <= '0;
            shift_type_r <= 1'b1;
            last_cycle_r <= (LIN_LAST == '0);
          end else begin
            cyc_cnt_r    <= cyc_nxt_s;
            last_cycle_r <= (cyc_nxt_s == SUB_LAST);
          end
        end
        ST_LIN: begin
          if (cyc_cnt_r == LIN_LAST) begin
            cyc_cnt_r <= '0;
            if (rnd_cnt_r == 4'd0) begin
              state_r      <= ST_DONE;
              shift_en_r   <= 1'b0;
              shift_type_r <= 1'b0;
              last_cycle_r <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
            end else begin
              state_r      <= ST_SUB;
              rnd_cnt_r    <= rnd_cnt_r - 4'd1;
              round_idx_r  <= round_idx_r + 4'd1;
              shift_type_r <= 1'b0;
              last_cycle_r <= (SUB_LAST == '0);
            end
          end else begin
            cyc_cnt_r    <= cyc_nxt_s;
            last_cycle_r <= (cyc_nxt_s == LIN_LAST);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          cyc_cnt_r    <= '0;
          rnd_cnt_r    <= 4'd0;
          shift_en_r   <= 1'b0;
          shift_type_r <= 1'b0;
          last_cycle_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perm_shift_ctrl.sv
// Directed, scoreboard-driven bench for perm_shift_ctrl. Each run pushes the
// expected per-cycle control vector into a queue when start is driven; every
// following falling edge pops one entry and compares it with the DUT.
module tb_perm_shift_ctrl;
  import perm_shift_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b, load_req;
  logic [3:0] num_rounds;

  logic       we_a, se_a, st_a, lc_a, busy_a, done_a;
  logic [3:0] ri_a;
  logic [7:0] rc_a;
  logic       we_b, se_b, st_b, lc_b, busy_b, done_b;
  logic [3:0] ri_b;
  logic [7:0] rc_b;

  // {shift_en, shift_type, last_cycle, round_idx, rc, busy, done, write_en}
  typedef logic [17:0] vec_t;
  vec_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         sel    = 0;
  logic [3:0] m_idx [2];
  logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  always #5 clk = ~clk;

  // DUT a: PAR=1, d=1 -> 32 substitution and 64 linear cycles per round.
  perm_shift_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .num_rounds(num_rounds),
    .load_req(load_req), .write_en(we_a), .shift_en(se_a), .shift_type(st_a),
    .last_cycle(lc_a), .round_idx(ri_a), .rc(rc_a), .busy(busy_a), .done(done_a)
  );

  // DUT b: PAR=2, d=31 -> single substitution cycle, 32 linear cycles.
  perm_shift_ctrl #(.WORD_SIZE(64), .SHIFT_PAR(2), .SHIFT_PAR_D_PLUS_1(64)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .num_rounds(num_rounds),
    .load_req(1'b0), .write_en(we_b), .shift_en(se_b), .shift_type(st_b),
    .last_cycle(lc_b), .round_idx(ri_b), .rc(rc_b), .busy(busy_b), .done(done_b)
  );

  function automatic vec_t obs();
    if (sel == 1) return {se_b, st_b, lc_b, ri_b, rc_b, busy_b, done_b, we_b};
    else          return {se_a, st_a, lc_a, ri_a, rc_a, busy_a, done_a, we_a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected cycle-by-cycle controls for one run, ending with the done cycle.
  task automatic push_run(input int d, input int nr, input int nsub, input int nlin);
    logic [3:0] idx;
    if (nr >= 1 && nr <= 12) begin
      for (int r = 0; r < nr; r++) begin
        idx = 4'(12 - nr + r);
        m_idx[d] = idx;
        for (int c = 0; c < nsub; c++)
          exp_q.push_back({1'b1, 1'b0, (c == nsub - 1), idx, rc_tab[idx], 1'b1, 1'b0, 1'b0});
        for (int c = 0; c < nlin; c++)
          exp_q.push_back({1'b1, 1'b1, (c == nlin - 1), idx, rc_tab[idx], 1'b1, 1'b0, 1'b0});
      end
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, m_idx[d], rc_tab[m_idx[d]], 1'b0, 1'b1, 1'b0});
  endtask

  // Start a run on DUT d and compare every cycle until the done cycle.
  // pulse_at: cycle at which start is re-pulsed while busy; abort_at: cycle
  // after which rst_n is dropped; hold_load keeps load_req high throughout.
  task automatic run(input int d, input int nr, input int pulse_at,
                     input bit hold_load, input int abort_at);
    int   n = 0;
    vec_t e;
    push_run(d, nr, (d == 1) ? 1 : 32, (d == 1) ? 32 : 64);
    sel        = d;
    num_rounds = 4'(nr);
    if (d == 1) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    load_req = hold_load;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      e = exp_q.pop_front();
      check($sformatf("d%0d_nr%0d_cyc%0d", d, nr, n), 32'(obs()), 32'(e));
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_async_clear", {25'd0, se_a, st_a, lc_a, ri_a, busy_a, done_a}, 32'd0);
        exp_q.delete();
        break;
      end
      start_a    = (d == 0) && (n == pulse_at);
      num_rounds = 4'd12;
    end
    start_a  = 1'b0;
    load_req = 1'b0;
    if (abort_at < 0) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    load_req   = 1'b0;
    num_rounds = 4'd0;
    m_idx[0]   = 4'd0;
    m_idx[1]   = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'({se_a, st_a, lc_a, ri_a, rc_a, busy_a, done_a, we_a}),
          32'({1'b0, 1'b0, 1'b0, 4'd0, 8'hF0, 1'b0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    @(negedge clk);

    // Parallel load request in IDLE, then load request colliding with start.
    load_req = 1'b1;
    #1 check("idle_load_we", 32'(we_a), 32'd1);
    load_req = 1'b0;
    #1 check("idle_noload_we", 32'(we_a), 32'd0);
    @(negedge clk);
    load_req   = 1'b1;
    start_a    = 1'b1;
    num_rounds = 4'd2;
    #1 check("start_beats_load_we", 32'(we_a), 32'd0);
    run(0, 2, -1, 1'b1, -1);

    // Full p^12 with a stray start pulse mid-run, then p^6.
    run(0, 12, 500, 1'b0, -1);
    run(0, 6, -1, 1'b0, -1);

    // Out-of-range round counts finish immediately with no shifting.
    run(0, 0, -1, 1'b0, -1);
    run(0, 13, -1, 1'b0, -1);

    // Abort mid-LIN of round 3 (cycle 234 of 288 in that round span).
    run(0, 12, -1, 1'b0, 234);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'({se_a, busy_a, done_a}), 32'd0);
    end
    rst_n    = 1'b1;
    m_idx[0] = 4'd0;
    m_idx[1] = 4'd0;
    @(negedge clk);
    run(0, 8, -1, 1'b0, -1);

    // Wide substitution path: one SUB cycle per round.
    run(1, 2, -1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
